spi_sample_server: RTL and testbench

SPI_SAMPLE_SERVER -- requirements
Module: spi_sample_server

---
 rtl/spi_sample_server_pkg.sv | 38 +++
 rtl/spi_sample_server_fifo.sv | 73 +++++++
 rtl/spi_sample_server.sv | 169 ++++++++++++++++
 tb/tb_spi_sample_server.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sample_server_pkg.sv
// Shared definitions for the SPI sample server: command opcodes, fixed tx
// marker words, status word bit positions and the status word packer.
package spi_sample_server_pkg;

  typedef enum logic [0:0] {
    S_CMD    = 1'b0,
    S_STREAM = 1'b1
  } state_e;

  // Command opcodes, carried in rx_data[15:12]
  localparam logic [3:0] OP_STREAM = 4'h1;
  localparam logic [3:0] OP_STATUS = 4'h2;
  localparam logic [3:0] OP_CTRL   = 4'h3;

  // Fixed words presented on tx_data
  localparam logic [15:0] TX_IDLE     = 16'h0000;
  localparam logic [15:0] TX_UNDERRUN = 16'hFFFF;
  localparam logic [15:0] TX_BADOP    = 16'hEEEE;

  // Status word layout: {ovf, unf, en, 8'b0, level[4:0]}
  localparam int ST_OVF_BIT = 15;
  localparam int ST_UNF_BIT = 14;
  localparam int ST_EN_BIT  = 13;
  localparam int ST_LVL_W   = 5;

  function automatic logic [15:0] pack_status(input logic ovf, input logic unf,
                                              input logic en,
                                              input logic [ST_LVL_W-1:0] lvl);
    logic [15:0] w;
    w               = '0;
    w[ST_OVF_BIT]   = ovf;
    w[ST_UNF_BIT]   = unf;
    w[ST_EN_BIT]    = en;
    w[ST_LVL_W-1:0] = lvl;
    return w;
  endfunction

endpackage

// File: rtl/spi_sample_server_fifo.sv
// sample_fifo: 16-bit sample FIFO, DEPTH words (power of two).
// Ports:
//   clk, rst_n        clock, async active-low reset
//   push_i, wdata_i   write request and data
//   pop_i             read request (head is on rdata_o)
//   flush_i           empty the FIFO; wins over a simultaneous push
//   rdata_o           head word; when empty, bypasses wdata_i
//   full_o, empty_o   occupancy flags
//   pop_ok_o          a pop this cycle returns real data (non-empty, or bypass)
//   drop_o            push this cycle is lost because the FIFO is full
//   level_o           occupancy, 0..DEPTH
module sample_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [15:0]              wdata_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [15:0]              rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     pop_ok_o,
  output logic                     drop_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q;
  logic          push_acc, pop_acc;

  assign empty_o = (lvl_q == '0);
  assign full_o  = (lvl_q == FULL_LVL);
  assign level_o = lvl_q;

  // Full + pop frees a slot for the push; empty + push lets the pop take the
  // incoming word straight through.
  assign push_acc = push_i & ~flush_i & (~full_o | pop_i);
  assign pop_acc  = pop_i  & ~flush_i & (~empty_o | push_i);
  assign pop_ok_o = ~empty_o | (push_i & ~flush_i);
  assign drop_o   = push_i & ~flush_i & full_o & ~pop_i;
  assign rdata_o  = empty_o ? wdata_i : mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (push_acc) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (push_acc) wr_q <= wr_q + 1'b1;
      if (pop_acc)  rd_q <= rd_q + 1'b1;
      case ({push_acc, pop_acc})
        2'b10:   lvl_q <= lvl_q + 1'b1;
        2'b01:   lvl_q <= lvl_q - 1'b1;
        default: lvl_q <= lvl_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_sample_server.sv
// spi_sample_server: serves buffered microphone samples over an SPI slave.
// A command word selects STREAM (send N samples), STATUS or CTRL; the reply
// word is presented on tx_data one cycle after the command completes.
// Ports:
//   clk, rst_n            clock, async active-low reset (release synchronized)
//   ssel                  raw chip select pad, active-low
//   word_rx, rx_data      completed SPI word strobe and data
//   data_needed           SPI shifter loading tx_data (tx_data is held stable)
//   tx_data               next word to shift out
//   sample_valid/_data    microphone sample strobe and data
//   enable                capture enable
//   fifo_level            FIFO occupancy
module spi_sample_server
  import spi_sample_server_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ssel,
  input  logic                   word_rx,
  input  logic [15:0]            rx_data,
  input  logic                   data_needed,
  output logic [15:0]            tx_data,
  input  logic                   sample_valid,
  input  logic [15:0]            sample_data,
  output logic                   enable,
  output logic [$clog2(DEPTH):0] fifo_level
);

  state_e      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [15:0] tx_q, tx_d;
  logic        en_q, en_d, ovf_q, ovf_d, unf_q, unf_d;
  logic [1:0]  ssel_sync_q, rst_sync_q;

  logic        run, frame_active, cmd_word, push_req, pop, flush;
  logic [3:0]  opcode;
  logic [15:0] fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_pop_ok, fifo_drop;
  logic        unused_ok;

  assign unused_ok = ^{data_needed, rx_data[11:8], fifo_full, fifo_empty};

  // Reset assertion is immediate; release reaches the FSM two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign run = rst_sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ssel_sync_q <= 2'b11;
    else        ssel_sync_q <= {ssel_sync_q[0], ssel};
  end
  assign frame_active = ~ssel_sync_q[1];

  assign opcode   = rx_data[15:12];
  assign cmd_word = run & frame_active & word_rx;
  assign push_req = run & sample_valid & en_q;

  // Pop and flush are decoded apart from the main next-state block so the
  // FIFO's combinational outputs never loop back into it.
  assign pop = cmd_word &
               (((state_q == S_CMD) && (opcode == OP_STREAM) && (rx_data[7:0] != 8'd0)) ||
                ((state_q == S_STREAM) && (rem_q != 8'd1)));
  assign flush = cmd_word & (state_q == S_CMD) & (opcode == OP_CTRL) & rx_data[2];

  sample_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_i   (push_req),
    .wdata_i  (sample_data),
    .pop_i    (pop),
    .flush_i  (flush),
    .rdata_o  (fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .pop_ok_o (fifo_pop_ok),
    .drop_o   (fifo_drop),
    .level_o  (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_CMD;
      rem_q   <= '0;
      tx_q    <= TX_IDLE;
      en_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      tx_q    <= tx_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    tx_d    = tx_q;
    en_d    = en_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (!run) begin
      state_d = S_CMD;
      rem_d   = '0;
      tx_d    = TX_IDLE;
      en_d    = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else begin
      if (!frame_active) begin
        // Any word already popped into tx_q is discarded here.
        state_d = S_CMD;
        rem_d   = '0;
        tx_d    = TX_IDLE;
      end else if (word_rx) begin
        case (state_q)
          S_CMD: begin
            case (opcode)
              OP_STREAM: begin
                rem_d = rx_data[7:0];
                if (rx_data[7:0] == 8'd0) tx_d = TX_IDLE;
                else                      state_d = S_STREAM;
              end
              OP_STATUS: tx_d = pack_status(ovf_q, unf_q, en_q, ST_LVL_W'(fifo_level));
              OP_CTRL: begin
                en_d = rx_data[0];
                if (rx_data[1]) begin
                  ovf_d = 1'b0;
                  unf_d = 1'b0;
                end
                tx_d = TX_IDLE;
              end
              default: tx_d = TX_BADOP;
            endcase
          end
          S_STREAM: begin
            rem_d = rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_d = S_CMD;
              tx_d    = TX_IDLE;
            end
          end
          default: state_d = S_CMD;
        endcase
      end
      if (pop) begin
        if (fifo_pop_ok) begin
          tx_d = fifo_rdata;
        end else begin
          tx_d  = TX_UNDERRUN;
          unf_d = 1'b1;
        end
      end
      // A drop in the same cycle as a CTRL clear still leaves overflow set.
      if (fifo_drop) ovf_d = 1'b1;
    end
  end

  assign tx_data = tx_q;
  assign enable  = en_q;

endmodule

// File: tb/tb_spi_sample_server.sv
module tb_spi_sample_server;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ssel = 1'b1;
  logic        word_rx = 1'b0;
  logic [15:0] rx_data = '0;
  logic        data_needed = 1'b0;
  logic        sample_valid = 1'b0;
  logic [15:0] sample_data = '0;
  logic [15:0] tx_data;
  logic        enable;
  logic [4:0]  fifo_level;

  int checks = 0;
  int failures = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  spi_sample_server #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ssel         (ssel),
    .word_rx      (word_rx),
    .rx_data      (rx_data),
    .data_needed  (data_needed),
    .tx_data      (tx_data),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .enable       (enable),
    .fifo_level   (fifo_level)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: sample queue, sticky flags, words left in a stream.
  logic [15:0] q[$];
  logic [15:0] m_tx;
  bit          m_en, m_ovf, m_unf, m_stream;
  int          m_rem, m_rel;
  bit [1:0]    m_sh;

  always @(posedge clk or negedge rst_n) begin : model
    bit fa, act, push, want_pop, flush, took, ovf_set, clr, nen;
    if (!rst_n) begin
      q.delete();
      m_tx = 16'h0000; m_en = 0; m_ovf = 0; m_unf = 0; m_stream = 0;
      m_rem = 0; m_rel = 0; m_sh = 2'b11;
    end else begin
      fa   = !m_sh[1];            // chip select seen two edges late
      m_sh = {m_sh[0], ssel};
      act  = (m_rel >= 2);        // reset release also seen two edges late
      if (m_rel < 2) m_rel++;
      if (act) begin
        push = sample_valid && m_en;
        want_pop = 0; flush = 0; took = 0; ovf_set = 0; clr = 0; nen = m_en;
        if (!fa) begin
          m_stream = 0; m_rem = 0; m_tx = 16'h0000;
        end else if (word_rx) begin
          if (!m_stream) begin
            case (rx_data[15:12])
              4'h1: begin
                m_rem = int'(rx_data[7:0]);
                if (m_rem == 0) m_tx = 16'h0000;
                else begin m_stream = 1; want_pop = 1; end
              end
              4'h2: m_tx = {m_ovf, m_unf, m_en, 8'h00, 5'(q.size())};
              4'h3: begin
                nen = rx_data[0]; clr = rx_data[1]; flush = rx_data[2]; m_tx = 16'h0000;
              end
              default: m_tx = 16'hEEEE;
            endcase
          end else begin
            m_rem--;
            if (m_rem == 0) begin m_stream = 0; m_tx = 16'h0000; end
            else want_pop = 1;
          end
        end
        if (flush) q.delete();
        else begin
          if (want_pop) begin
            if (q.size() != 0) m_tx = q.pop_front();
            else if (push) begin m_tx = sample_data; took = 1; end
            else begin m_tx = 16'hFFFF; m_unf = 1; end
          end
          if (push && !took) begin
            if (q.size() < DEPTH) q.push_back(sample_data);
            else ovf_set = 1;
          end
        end
        if (clr) begin m_ovf = 0; m_unf = 0; end
        if (ovf_set) m_ovf = 1;
        m_en = nen;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model tx_data", {16'h0, tx_data}, {16'h0, m_tx});
      chk("model enable", {31'h0, enable}, {31'h0, m_en});
      chk("model fifo_level", {27'h0, fifo_level}, 32'(q.size()));
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [15:0] d, output logic [15:0] got);
    word_rx = 1'b1; rx_data = d;
    tick();
    word_rx = 1'b0;
    got = tx_data;
  endtask

  task automatic sendx(input string name, input logic [15:0] d, input logic [15:0] exp);
    logic [15:0] got;
    send(d, got);
    chk(name, {16'h0, got}, {16'h0, exp});
  endtask

  task automatic push_s(input logic [15:0] d);
    sample_valid = 1'b1; sample_data = d;
    tick();
    sample_valid = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : stim
    logic [15:0] got;
    logic [15:0] w;
    int r;
    tick(2);
    cmp_on = 1'b1;
    chk("reset tx_data", {16'h0, tx_data}, 32'h0);
    chk("reset enable", {31'h0, enable}, 32'h0);
    chk("reset fifo_level", {27'h0, fifo_level}, 32'h0);
    rst_n = 1'b1;
    tick(4);
    ssel = 1'b0;
    tick(3);

    // Basic stream of three samples
    sendx("ctrl enable", 16'h3001, 16'h0000);
    chk("enable set", {31'h0, enable}, 32'h1);
    push_s(16'h0101); push_s(16'h0202); push_s(16'h0303);
    chk("level 3", {27'h0, fifo_level}, 32'd3);
    sendx("stream s1", 16'h1003, 16'h0101);
    sendx("stream s2", 16'h0000, 16'h0202);
    sendx("stream s3", 16'h0000, 16'h0303);
    sendx("stream end", 16'h0000, 16'h0000);
    chk("level 0", {27'h0, fifo_level}, 32'd0);

    // Underflow on an empty FIFO
    sendx("underrun 1", 16'h1002, 16'hFFFF);
    sendx("underrun 2", 16'h0000, 16'hFFFF);
    sendx("underrun end", 16'h0000, 16'h0000);
    sendx("status unf", 16'h2000, 16'h6000);
    sendx("ctrl clear", 16'h3003, 16'h0000);
    sendx("status clean", 16'h2000, 16'h2000);

    // Overflow: 17 pushes into 16 slots
    for (int i = 0; i < 17; i++) push_s(16'h1000 + 16'(i));
    chk("level full", {27'h0, fifo_level}, 32'd16);
    sendx("status ovf", 16'h2000, 16'hA010);
    sendx("ctrl clear2", 16'h3003, 16'h0000);
    sendx("status cleared", 16'h2000, 16'h2010);

    // Full FIFO: push and pop together
    sample_valid = 1'b1; sample_data = 16'hBEEF;
    send(16'h1001, got);
    sample_valid = 1'b0;
    chk("full pop head", {16'h0, got}, 32'h1000);
    chk("full level kept", {27'h0, fifo_level}, 32'd16);
    sendx("full stream end", 16'h0000, 16'h0000);
    sendx("status no ovf", 16'h2000, 16'h2010);
    sendx("drain first", 16'h1010, 16'h1001);
    for (int i = 1; i <= 15; i++) begin
      send(16'h0000, got);
      if (i == 15) chk("new sample last", {16'h0, got}, 32'hBEEF);
    end
    sendx("drain end", 16'h0000, 16'h0000);
    chk("drained", {27'h0, fifo_level}, 32'd0);

    // Frame abort mid-stream
    for (int i = 1; i <= 5; i++) push_s(16'h0A00 + 16'(i));
    sendx("abort s1", 16'h1005, 16'h0A01);
    sendx("abort s2", 16'h0000, 16'h0A02);
    sendx("abort s3", 16'h0000, 16'h0A03);
    ssel = 1'b1;
    tick(3);
    chk("abort tx idle", {16'h0, tx_data}, 32'h0);
    chk("abort level", {27'h0, fifo_level}, 32'd2);
    ssel = 1'b0;
    tick(3);
    sendx("after abort cmd", 16'h1002, 16'h0A04);
    sendx("after abort s2", 16'h0000, 16'h0A05);
    sendx("after abort end", 16'h0000, 16'h0000);

    // Async reset mid-stream
    push_s(16'h0B01); push_s(16'h0B02);
    sendx("pre-reset stream", 16'h1005, 16'h0B01);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst tx", {16'h0, tx_data}, 32'h0);
    chk("async rst enable", {31'h0, enable}, 32'h0);
    chk("async rst level", {27'h0, fifo_level}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    sendx("bad opcode", 16'h7000, 16'hEEEE);
    sendx("stream zero", 16'h1000, 16'h0000);
    sendx("ctrl enable2", 16'h3001, 16'h0000);

    // Randomized traffic checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      sample_valid = ($urandom_range(0, 2) == 0);
      sample_data  = 16'($urandom);
      data_needed  = 1'($urandom_range(0, 1));
      word_rx      = ($urandom_range(0, 3) == 0);
      r = $urandom_range(0, 9);
      if (r <= 3)      w = {4'h1, 4'h0, 8'($urandom_range(0, 6))};
      else if (r == 4) w = 16'h2000;
      else if (r <= 6) w = {4'h3, 9'h0, 1'($urandom_range(0, 7) == 0),
                            1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0)};
      else if (r == 7) w = {4'($urandom_range(4, 15)), 12'($urandom)};
      else             w = 16'($urandom);
      rx_data = w;
      if (ssel == 1'b0) begin
        if ($urandom_range(0, 199) == 0) ssel = 1'b1;
      end else if ($urandom_range(0, 9) == 0) ssel = 1'b0;
      if (c == 1500) rst_n = 1'b0;
      if (c == 1503) rst_n = 1'b1;
      if (c == 1510) begin
        word_rx = 1'b1; rx_data = 16'h3001;
      end
      tick();
    end
    word_rx = 1'b0; sample_valid = 1'b0;
    tick(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
